// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: opcode field position and FSM state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package instr_fetch_unit_pkg;

    // Opcode field of a 32-bit instruction word, forwarded to the main control decoder
    localparam int OP_MSB = 31;
    localparam int OP_LSB = 26;

    // Fetch FSM: IDLE waits for a free slot, REQ fetches at fetch_pc,
    // DRAIN holds a pre-redirect request until its (discarded) ack arrives
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRAIN = 2'd2
    } ifu_state_e;

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous FIFO of {pc, instr} entries with push, pop, flush and occupancy count.
// Latency: a push is visible at the head one cycle later.
// Backpressure: push when full and pop when empty are ignored; flush wins over push.
module ifu_fifo #(
    parameter int DW    = 64,
    parameter int DEPTH = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [DW-1:0]              push_dat_i,
    input  logic                       pop_i,
    output logic [DW-1:0]              head_dat_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign do_push = push_i && !flush_i && (count_q != CW'(DEPTH));
    assign do_pop  = pop_i && (count_q != '0);

    // Pointer/count update; DEPTH is a power of two so pointers wrap naturally
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + AW'(do_push);
            rd_ptr_d = rd_ptr_q + AW'(do_pop);
            count_d  = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Control state flops
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only observed while counted valid
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    assign head_dat_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;
    assign empty_o    = (count_q == '0);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: PC, imem req/ack fetch FSM, {pc, instr} buffer toward decode.
// Latency: ack at N -> instr_valid_o at N+1; redirect at N -> request at new PC at N+1.
// Backpressure: instr_ready_i=0 holds the head; fetch stops when every slot is filled or reserved.
// Optional IFU_PERF_EN adds delivered-instruction and redirect counters.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                FIFO_DEPTH = 2,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_ack_i,
    input  logic [31:0]       imem_rdata_i,
    output logic              instr_valid_o,
    input  logic              instr_ready_i,
    output logic [31:0]       instr_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic [5:0]        op_o,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i
`ifdef IFU_PERF_EN
    ,
    output logic [31:0]       fetch_cnt_o,
    output logic [31:0]       redirect_cnt_o
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int DW = ADDR_W + 32;

    ifu_state_e        state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              req_q, req_d;

    logic [DW-1:0]     head_dat;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_nxt;
    logic              empty;
    logic              push;
    logic              pop;
    logic              slot_ok;

    // A live response is only taken in REQ; a redirect in the same cycle drops it
    assign push      = (state_q == ST_REQ) && imem_ack_i && !redirect_i;
    assign pop       = instr_valid_o && instr_ready_i;
    assign count_nxt = redirect_i ? '0 : (count + CW'(push) - CW'(pop));
    assign slot_ok   = (count_nxt < CW'(FIFO_DEPTH));

    ifu_fifo #(
        .DW    (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .flush_i    (redirect_i),
        .push_i     (push),
        .push_dat_i ({fetch_pc_q, imem_rdata_i}),
        .pop_i      (pop),
        .head_dat_o (head_dat),
        .count_o    (count),
        .empty_o    (empty)
    );

    // Next fetch state, PC and registered request address; redirect overrides everything
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        case (state_q)
            ST_IDLE: begin
                if (count < CW'(FIFO_DEPTH)) begin
                    state_d = ST_REQ;
                    addr_d  = fetch_pc_q;
                end
            end
            ST_REQ: begin
                if (imem_ack_i) begin
                    fetch_pc_d = fetch_pc_q + ADDR_W'(4);
                    addr_d     = fetch_pc_q + ADDR_W'(4);
                    state_d    = slot_ok ? ST_REQ : ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (imem_ack_i) begin
                    addr_d  = fetch_pc_q;
                    state_d = slot_ok ? ST_REQ : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (redirect_i) begin
            fetch_pc_d = redirect_pc_i;
            if ((state_q != ST_IDLE) && !imem_ack_i) begin
                // Outstanding request cannot be withdrawn: keep its address until acked
                state_d = ST_DRAIN;
                addr_d  = addr_q;
            end else begin
                state_d = ST_REQ;
                addr_d  = redirect_pc_i;
            end
        end
        req_d = (state_d != ST_IDLE);
    end

    // FSM, PC and registered imem request outputs
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= '0;
            req_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            req_q      <= req_d;
        end
    end

    assign imem_req_o    = req_q;
    assign imem_addr_o   = addr_q;
    assign instr_valid_o = !empty;
    assign instr_o       = instr_valid_o ? head_dat[31:0] : '0;
    assign pc_o          = instr_valid_o ? head_dat[DW-1:32] : '0;
    assign op_o          = instr_o[OP_MSB:OP_LSB];

`ifdef IFU_PERF_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] redirect_cnt_q, redirect_cnt_d;

    // Wrapping event counters: delivered instructions and redirects
    always_comb begin
        fetch_cnt_d    = fetch_cnt_q + 32'(pop);
        redirect_cnt_d = redirect_cnt_q + 32'(redirect_i);
    end

    // Counter flops
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fetch_cnt_q    <= '0;
            redirect_cnt_q <= '0;
        end else begin
            fetch_cnt_q    <= fetch_cnt_d;
            redirect_cnt_q <= redirect_cnt_d;
        end
    end

    assign fetch_cnt_o    = fetch_cnt_q;
    assign redirect_cnt_o = redirect_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios then randomized ack/ready/redirect traffic,
// checked every cycle against a transaction-level model (expected instruction stream queue,
// expected next fetch address, stale-response tracking, slot reservation, request hold).
module tb_instr_fetch_unit;

    localparam int FIFO_DEPTH = 2;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [5:0]  op_o;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
`ifdef IFU_PERF_EN
    logic [31:0] fetch_cnt_o;
    logic [31:0] redirect_cnt_o;
`endif

    instr_fetch_unit #(
        .ADDR_W     (32),
        .FIFO_DEPTH (FIFO_DEPTH),
        .RESET_PC   (32'h0000_0000)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .imem_req_o     (imem_req_o),
        .imem_addr_o    (imem_addr_o),
        .imem_ack_i     (imem_ack_i),
        .imem_rdata_i   (imem_rdata_i),
        .instr_valid_o  (instr_valid_o),
        .instr_ready_i  (instr_ready_i),
        .instr_o        (instr_o),
        .pc_o           (pc_o),
        .op_o           (op_o),
        .redirect_i     (redirect_i),
        .redirect_pc_i  (redirect_pc_i)
`ifdef IFU_PERF_EN
        ,
        .fetch_cnt_o    (fetch_cnt_o),
        .redirect_cnt_o (redirect_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [31:0] q_pc[$];
    logic [31:0] q_dat[$];
    logic [31:0] exp_pc;
    bit          stale;
    bit          prev_req;
    bit          prev_ack;
    logic [31:0] prev_addr;
    int          n_pops;
    int          n_redir;
    int          total_pops = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q_pc.delete();
        q_dat.delete();
        exp_pc   = 32'h0;
        stale    = 1'b0;
        prev_req = 1'b0;
        prev_ack = 1'b0;
        prev_addr = '0;
        n_pops   = 0;
        n_redir  = 0;
    endtask

    task automatic do_reset();
        rst_i         = 1'b0;
        imem_ack_i    = 1'b0;
        instr_ready_i = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        #1;
        chk("rst_req", imem_req_o, 1'b0);
        chk("rst_valid", instr_valid_o, 1'b0);
        chk("rst_instr", instr_o, 32'h0);
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_op", op_o, 6'h0);
`ifdef IFU_PERF_EN
        chk("rst_fcnt", fetch_cnt_o, 32'h0);
        chk("rst_rcnt", redirect_cnt_o, 32'h0);
`endif
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
    endtask

    // One cycle: check outputs against the model, drive inputs, advance the model, clock.
    task automatic step(input bit want_ack, input bit rdy, input bit redir, input logic [31:0] rpc);
        bit          ack;
        bit          live_req;
        logic [31:0] dat;
        logic [31:0] head;
        live_req = imem_req_o && !stale;
        chk("valid", instr_valid_o, q_pc.size() != 0);
        if (q_pc.size() != 0) begin
            head = q_dat[0];
            chk("pc", pc_o, q_pc[0]);
            chk("instr", instr_o, head);
            chk("op", op_o, head[31:26]);
        end
        if (prev_req && !prev_ack)
            chk("hold", {imem_req_o, imem_addr_o}, {1'b1, prev_addr});
        if (live_req)
            chk("addr", imem_addr_o, exp_pc);
        chk("slots", (q_pc.size() + int'(live_req)) <= FIFO_DEPTH, 1'b1);

        ack = want_ack && imem_req_o;
        dat = $urandom;
        imem_ack_i    = ack;
        imem_rdata_i  = dat;
        instr_ready_i = rdy;
        redirect_i    = redir;
        redirect_pc_i = rpc;

        if (q_pc.size() != 0 && rdy) begin
            void'(q_pc.pop_front());
            void'(q_dat.pop_front());
            n_pops++;
            total_pops++;
        end
        if (ack) begin
            if (stale) begin
                stale = 1'b0;
            end else if (!redir) begin
                q_pc.push_back(exp_pc);
                q_dat.push_back(dat);
                exp_pc = exp_pc + 32'd4;
            end
        end
        if (redir) begin
            q_pc.delete();
            q_dat.delete();
            exp_pc = rpc;
            if (imem_req_o && !ack) stale = 1'b1;
            n_redir++;
        end
        prev_req  = imem_req_o;
        prev_addr = imem_addr_o;
        prev_ack  = ack;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        bit          r_ack, r_rdy, r_red;
        logic [31:0] r_pc;
        imem_rdata_i = '0;
        do_reset();

        // Streaming: ack every cycle, ready=1
        step(1, 1, 0, 0);
        chk("req_first", {imem_req_o, imem_addr_o}, {1'b1, 32'h0});
        repeat (8) step(1, 1, 0, 0);

        // Stall: exactly FIFO_DEPTH acks accepted, then no request; resume at 0x8
        do_reset();
        repeat (6) step(1, 0, 0, 0);
        chk("full_noreq", imem_req_o, 1'b0);
        chk("full_head", pc_o, 32'h0);
        for (int i = 0; i < 8 && !imem_req_o; i++) step(0, 1, 0, 0);
        chk("resume", {imem_req_o, imem_addr_o}, {1'b1, 32'h8});

        // Redirect while a request waits for ack: old address held, its word never delivered
        step(0, 1, 0, 0);
        step(0, 1, 1, 32'h100);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        chk("drain_hold", {imem_req_o, imem_addr_o}, {1'b1, 32'h8});
        step(1, 1, 0, 0);
        chk("drain_next", {imem_req_o, imem_addr_o}, {1'b1, 32'h100});
        chk("drain_novalid", instr_valid_o, 1'b0);

        // Redirect and ack together: word dropped, next request at target
        step(1, 1, 1, 32'h200);
        chk("redir_ack_valid", instr_valid_o, 1'b0);
        chk("redir_ack_next", {imem_req_o, imem_addr_o}, {1'b1, 32'h200});

        // PC wrap at the top of the address space
        step(1, 1, 1, 32'hFFFF_FFFC);
        chk("wrap_at", imem_addr_o, 32'hFFFF_FFFC);
        step(1, 1, 0, 0);
        chk("wrap_next", {imem_req_o, imem_addr_o}, {1'b1, 32'h0});
        chk("wrap_pc", pc_o, 32'hFFFF_FFFC);

        // Reset in the middle of a pending request, then restart at RESET_PC
        step(0, 0, 0, 0);
        do_reset();
        step(0, 0, 0, 0);
        chk("rst_restart", {imem_req_o, imem_addr_o}, {1'b1, 32'h0});

        // Five deliveries and two redirects
        for (int i = 0; i < 20 && n_pops < 5; i++) step(1, 1, 0, 0);
        step(1, 0, 1, 32'h40);
        step(1, 0, 1, 32'h80);
        step(0, 0, 0, 0);
`ifdef IFU_PERF_EN
        chk("fetch_cnt5", fetch_cnt_o, 32'd5);
        chk("redir_cnt2", redirect_cnt_o, 32'd2);
`endif

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            r_ack = ($urandom_range(99) < 60);
            r_rdy = ($urandom_range(99) < 70);
            r_red = ($urandom_range(99) < 5);
            r_pc  = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC))
                                             : ($urandom & 32'hFFFF_FFFC);
            step(r_ack, r_rdy, r_red, r_pc);
        end
        chk("progress", total_pops > 200, 1'b1);
`ifdef IFU_PERF_EN
        chk("fetch_cnt", fetch_cnt_o, 32'(n_pops));
        chk("redir_cnt", redirect_cnt_o, 32'(n_redir));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
